clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 154 +++++++++++++++
 tb/tb_clk_div_prog.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider.
// A divisor loaded through a pending register takes effect only at a period
// boundary, or on the following edge while stopped, so clk_out never shows a
// shortened phase. Divisors 0 and 1 behave as 2.
// Optional macro CLK_DIV_ODD50_EN adds a falling-edge register that stretches
// the high phase by half a cycle for odd divisors, giving an exact 50% duty.
module clk_div_prog #(
    parameter int CNT_W   = 8,
    parameter int RST_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic             pend
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] n_cur, n_cur_nx;
    logic [CNT_W-1:0] pend_val, pend_val_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pend_nx;
    logic             clk_r, clk_nx;
    logic             tick_nx;
    logic             active_nx;

    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic             boundary;

    // Effective divisor, high-phase length and period-boundary detect.
    always_comb begin
        n_eff    = (n_cur < CNT_W'(2)) ? CNT_W'(2) : n_cur;
        half     = n_eff >> 1;
        cnt_inc  = cnt + CNT_W'(1);
        boundary = (cnt == n_eff - CNT_W'(1));
    end

    // Next-state logic: divisor changes and start/stop happen only at a
    // boundary (RUN) or on any edge while stopped.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned; otherwise synthesis would infer a latch.
        state_nx    = state;
        n_cur_nx    = n_cur;
        pend_nx     = pend;
        pend_val_nx = pend_val;
        cnt_nx      = cnt;
        clk_nx      = clk_r;
        tick_nx     = 1'b0;

        case (state)
            ST_STOP: begin
                // A divisor loaded while stopped is adopted one edge later.
                if (pend) begin
                    n_cur_nx = pend_val;
                    pend_nx  = 1'b0;
                end
                if (en) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                    clk_nx   = 1'b1;
                    tick_nx  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!boundary) begin
                    cnt_nx = cnt_inc;
                    clk_nx = (cnt_inc < half);
                end else begin
                    if (pend) begin
                        n_cur_nx = pend_val;
                        pend_nx  = 1'b0;
                    end
                    cnt_nx = '0;
                    if (en) begin
                        clk_nx  = 1'b1;
                        tick_nx = 1'b1;
                    end else begin
                        state_nx = ST_STOP;
                        clk_nx   = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = ST_STOP;
                cnt_nx   = '0;
                clk_nx   = 1'b0;
            end
        endcase

        // A load captured on a boundary edge still sets pend, so it is
        // applied at the next boundary rather than the current one.
        if (load) begin
            pend_val_nx = div_val;
            pend_nx     = 1'b1;
        end

        active_nx = (state_nx == ST_RUN);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= ST_STOP;
            n_cur    <= CNT_W'(RST_DIV);
            pend_val <= '0;
            pend     <= 1'b0;
            cnt      <= '0;
            clk_r    <= 1'b0;
            tick     <= 1'b0;
            active   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before the edge, independent of order.
            state    <= state_nx;
            n_cur    <= n_cur_nx;
            pend_val <= pend_val_nx;
            pend     <= pend_nx;
            cnt      <= cnt_nx;
            clk_r    <= clk_nx;
            tick     <= tick_nx;
            active   <= active_nx;
        end
    end

`ifdef CLK_DIV_ODD50_EN
    logic fall_r;

    // Half-cycle delayed copy of the divided clock, used only for odd divisors.
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            fall_r <= 1'b0;
        end else begin
            fall_r <= clk_r & n_eff[0];
        end
    end

    assign clk_out = clk_r | fall_r;
`else
    assign clk_out = clk_r;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed scenarios followed by random stimulus, compared
// every cycle against a waveform-queue reference model of the divider.
module tb_clk_div_prog;

    localparam int CNT_W   = 8;
    localparam int RST_DIV = 2;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             load;
    logic             clk_out;
    logic             tick;
    logic             active;
    logic             pend;

    clk_div_prog #(.CNT_W(CNT_W), .RST_DIV(RST_DIV)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div_val (div_val),
        .load    (load),
        .clk_out (clk_out),
        .tick    (tick),
        .active  (active),
        .pend    (pend)
    );

    always #5 clk_in = ~clk_in;

    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    // Reference model: the current period is held as a queue of clk_out
    // samples, one per cycle; the head is the sample shown now.
    bit m_run;
    int m_n;
    bit m_pend;
    int m_pval;
    bit m_tick;
    int m_plen;
    bit m_q[$];
    bit m_pre_fall;

    function automatic int eff(input int n);
        return (n < 2) ? 2 : n;
    endfunction

    function automatic void m_reset();
        m_run  = 1'b0;
        m_n    = RST_DIV;
        m_pend = 1'b0;
        m_pval = 0;
        m_tick = 1'b0;
        m_plen = 0;
        m_q.delete();
        m_pre_fall = 1'b0;
    endfunction

    function automatic void m_start(input int n);
        m_plen = eff(n);
        m_q.delete();
        for (int i = 0; i < m_plen; i++) m_q.push_back(i < m_plen / 2);
        m_tick = 1'b1;
    endfunction

    function automatic bit m_clk();
        return m_run ? m_q[0] : 1'b0;
    endfunction

    function automatic int m_cnt();
        return m_plen - m_q.size();
    endfunction

    function automatic void m_edge(input bit e, input bit l, input int dv);
        m_tick = 1'b0;
        if (m_run && m_q.size() > 1) begin
            void'(m_q.pop_front());
        end else begin
            if (m_pend) begin
                m_n    = m_pval;
                m_pend = 1'b0;
            end
            if (e) begin
                m_run = 1'b1;
                m_start(m_n);
            end else begin
                m_run = 1'b0;
                m_q.delete();
            end
        end
        if (l) begin
            m_pval = dv % 256;
            m_pend = 1'b1;
        end
    endfunction

    function automatic bit m_clk_out();
`ifdef CLK_DIV_ODD50_EN
        return m_clk() | m_pre_fall;
`else
        return m_clk();
`endif
    endfunction

    // One clock cycle: drive on the falling edge, model on the rising edge,
    // compare just after it.
    task automatic step(input bit e, input bit l, input int dv);
        @(negedge clk_in);
        en      = e;
        load    = l;
        div_val = dv[CNT_W-1:0];
        @(posedge clk_in);
        m_pre_fall = m_clk() && (eff(m_n) % 2 == 1);
        m_edge(e, l, dv);
        #1;
        check("clk_out", clk_out, m_clk_out());
        check("tick",    tick,    m_tick);
        check("active",  active,  m_run);
        check("pend",    pend,    m_pend);
    endtask

    task automatic run_until_cnt(input int target);
        int k = 0;
        while (!(m_run && m_cnt() == target) && k < 64) begin
            step(1'b1, 1'b0, 0);
            k++;
        end
        if (k >= 64) check("wait_cnt_timeout", 0, 1);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        div_val = '0;
        m_reset();
        #12;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick",    tick,    0);
        check("rst_active",  active,  0);
        check("rst_pend",    pend,    0);
        @(negedge clk_in);
        rst = 1'b0;

        // Divide by 4: loaded while stopped, then run.
        phase = "div4";
        step(1'b0, 1'b1, 4);
        step(1'b0, 1'b0, 0);
        repeat (12) step(1'b1, 1'b0, 0);

        // Odd divisor 5, loaded while running.
        phase = "div5";
        step(1'b1, 1'b1, 5);
        repeat (20) step(1'b1, 1'b0, 0);

        // Running at 4, load 6 at cnt=1: current period completes first.
        phase = "pend6";
        step(1'b1, 1'b1, 4);
        repeat (10) step(1'b1, 1'b0, 0);
        run_until_cnt(1);
        step(1'b1, 1'b1, 6);
        repeat (16) step(1'b1, 1'b0, 0);

        // Two loads in one period: the last one wins.
        phase = "last_wins";
        run_until_cnt(1);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 8);
        repeat (20) step(1'b1, 1'b0, 0);

        // Load on the boundary edge applies one period later.
        phase = "load_at_boundary";
        run_until_cnt(7);
        step(1'b1, 1'b1, 5);
        repeat (20) step(1'b1, 1'b0, 0);

        // Drop en mid-period at N=6: period completes, then stop.
        phase = "stop6";
        step(1'b1, 1'b1, 6);
        repeat (10) step(1'b1, 1'b0, 0);
        run_until_cnt(2);
        repeat (12) step(1'b0, 1'b0, 0);

        // Divisors 0 and 1 behave as 2.
        phase = "div0";
        step(1'b0, 1'b1, 0);
        repeat (10) step(1'b1, 1'b0, 0);
        phase = "div1";
        step(1'b1, 1'b1, 1);
        repeat (10) step(1'b1, 1'b0, 0);

        // Asynchronous reset in the middle of a high phase with a load pending.
        phase = "async_rst";
        step(1'b1, 1'b1, 6);
        repeat (10) step(1'b1, 1'b0, 0);
        run_until_cnt(1);
        step(1'b1, 1'b1, 9);
        check("high_before_rst", clk_out, 1);
        @(negedge clk_in);
        #2;
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        #1;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick",    tick,    0);
        check("rst_active",  active,  0);
        check("rst_pend",    pend,    0);
        m_reset();
        @(negedge clk_in);
        rst = 1'b0;
        step(1'b0, 1'b0, 0);
        repeat (10) step(1'b1, 1'b0, 0);

        // Random en/load/div_val traffic.
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 9)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
